// File: rtl/uart_pkg.sv
// Shared state encodings, counter width and rate clamp for the UART transmitter.
package uart_pkg;

   localparam int CNT_W = 13;

   typedef logic [2:0] state_t;

   localparam logic [2:0] IDLE       = 3'b000;
   localparam logic [2:0] START_BIT  = 3'b001;
   localparam logic [2:0] DATA_BITS  = 3'b010;
   localparam logic [2:0] STOP_BIT   = 3'b011;
   localparam logic [2:0] PARITY_BIT = 3'b100;
   localparam logic [2:0] DONE       = 3'b101;

   // Rates of 0 or 1 cannot be timed by the bit counter, so they run as 2.
   function automatic logic [CNT_W-1:0] clamp_cpb(input logic [CNT_W-1:0] cpb);
      return (cpb < CNT_W'(2)) ? CNT_W'(2) : cpb;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit timer: counts clk cycles from a clear; bit_end flags the last cycle of a bit (count = limit-1).
module uart_baud_cnt
   import uart_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic [CNT_W-1:0] limit,
   output logic             bit_end
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

   assign bit_end = (count == limit - CNT_W'(1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, LSB first, stop bit high; even parity bit added when UART_TX_PARITY_EN is defined.
// tx/busy/done are flops and change on the edge that samples start; start is ignored while busy (no queueing).
module uart_tx
   import uart_pkg::*;
#(
   parameter int data_width = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CNT_W-1:0]      CLKS_PER_BIT,
   input  logic                  start,
   input  logic [data_width-1:0] data_in,
   output logic                  tx,
   output logic                  busy,
   output logic                  done
);

   localparam int BC_W = (data_width > 1) ? $clog2(data_width) : 1;
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(data_width - 1);

   state_t                state;
   logic [CNT_W-1:0]      cpb_q;
   logic [data_width-1:0] shreg;
   logic [BC_W-1:0]       bit_cnt;
   logic                  bit_end;
   logic                  cnt_clear;
`ifdef UART_TX_PARITY_EN
   logic                  parity_q;
`endif

   // The timer restarts at every bit boundary and is held at zero outside a frame.
   assign cnt_clear = (state == IDLE) || (state == DONE) || bit_end;

   uart_baud_cnt u_baud (
      .clk     (clk),
      .rst     (rst),
      .clear   (cnt_clear),
      .limit   (cpb_q),
      .bit_end (bit_end)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         tx      <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         cpb_q   <= '0;
         shreg   <= '0;
         bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= START_BIT;
                  tx    <= 1'b0;
                  busy  <= 1'b1;
                  cpb_q <= clamp_cpb(CLKS_PER_BIT);
                  shreg <= data_in;
`ifdef UART_TX_PARITY_EN
                  parity_q <= ^data_in;
`endif
               end
            end
            START_BIT: begin
               if (bit_end) begin
                  state   <= DATA_BITS;
                  tx      <= shreg[0];
                  shreg   <= shreg >> 1;
                  bit_cnt <= '0;
               end
            end
            DATA_BITS: begin
               if (bit_end) begin
                  if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                     state <= PARITY_BIT;
                     tx    <= parity_q;
`else
                     state <= STOP_BIT;
                     tx    <= 1'b1;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + BC_W'(1);
                     tx      <= shreg[0];
                     shreg   <= shreg >> 1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY_BIT: begin
               if (bit_end) begin
                  state <= STOP_BIT;
                  tx    <= 1'b1;
               end
            end
`endif
            STOP_BIT: begin
               if (bit_end) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: checks the serial waveform bit by bit against hand-derived frames.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic [12:0] cpb   = 13'd4;
   logic        start = 1'b0;
   logic [7:0]  din   = 8'h00;
   logic        tx;
   logic        busy;
   logic        done;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_tx #(.data_width(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .CLKS_PER_BIT (cpb),
      .start        (start),
      .data_in      (din),
      .tx           (tx),
      .busy         (busy),
      .done         (done)
   );

   // Frame bit k: 0 = start, 1..8 = data LSB first, then optional even parity, then stop.
   function automatic logic frame_bit(input logic [7:0] d, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
      if (k == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   // Raise start, then check every cycle of the frame, the done cycle and the idle cycle after it.
   task automatic send_frame(input logic [7:0] d, input int hold, input int eff, input string name);
      din   = d;
      start = 1'b1;
      @(posedge clk);
      #1;
      if (hold == 0) start = 1'b0;
      for (int k = 0; k < NBITS; k++) begin
         for (int c = 0; c < eff; c++) begin
            @(negedge clk);
            checks++;
            if (tx !== frame_bit(d, k) || busy !== 1'b1 || done !== 1'b0) begin
               failures++;
               $display("FAIL %s bit%0d cyc%0d: tx=%b busy=%b done=%b, want tx=%b busy=1 done=0",
                        name, k, c, tx, busy, done, frame_bit(d, k));
            end
         end
      end
      @(negedge clk);
      checks++;
      if ({tx, busy, done} !== 3'b111) begin
         failures++;
         $display("FAIL %s done_cycle: tx/busy/done=%b, want 111", name, {tx, busy, done});
      end
      @(negedge clk);
      checks++;
      if ({tx, busy, done} !== 3'b100) begin
         failures++;
         $display("FAIL %s idle_after_done: tx/busy/done=%b, want 100", name, {tx, busy, done});
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b1;
      din   = 8'hA5;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({tx, busy, done} !== 3'b100) begin
         failures++;
         $display("FAIL reset_state: tx/busy/done=%b, want 100", {tx, busy, done});
      end
      start = 1'b0;
      rst   = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({tx, busy, done} !== 3'b100) begin
         failures++;
         $display("FAIL idle_after_reset: tx/busy/done=%b, want 100", {tx, busy, done});
      end
   endtask

   task automatic test_single_frame();
      cpb = 13'd4;
      send_frame(8'hA5, 0, 4, "frame_a5");
      cpb = 13'd3;
      send_frame(8'h81, 0, 3, "frame_81_cpb3");
   endtask

   task automatic test_parity();
`ifdef UART_TX_PARITY_EN
      cpb = 13'd4;
      send_frame(8'h07, 0, 4, "parity_07");
      send_frame(8'h03, 0, 4, "parity_03");
`endif
   endtask

   task automatic test_busy_ignore();
      cpb = 13'd4;
      fork
         send_frame(8'hA5, 0, 4, "busy_ignore");
         begin
            @(posedge clk);
            #2;
            repeat (10) @(posedge clk);
            #1;
            din   = 8'hFF;
            cpb   = 13'd7;
            start = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            start = 1'b0;
            cpb   = 13'd4;
         end
      join
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checks++;
         if ({tx, busy, done} !== 3'b100) begin
            failures++;
            $display("FAIL busy_ignore_no_second_frame cyc%0d: tx/busy/done=%b, want 100",
                     i, {tx, busy, done});
         end
      end
   endtask

   task automatic test_back_to_back();
      cpb = 13'd4;
      send_frame(8'h00, 1, 4, "b2b_00");
      send_frame(8'h55, 1, 4, "b2b_55");
      start = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      cpb   = 13'd4;
      din   = 8'hA5;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (17) @(posedge clk);
      @(negedge clk);
      checks++;
      if (tx !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset_data_bit3: tx=%b busy=%b, want tx=0 busy=1", tx, busy);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({tx, busy, done} !== 3'b100) begin
         failures++;
         $display("FAIL reset_mid_frame: tx/busy/done=%b, want 100", {tx, busy, done});
      end
      rst = 1'b0;
      @(negedge clk);
      send_frame(8'h3C, 0, 4, "after_reset_3c");
   endtask

   task automatic test_min_rate();
      cpb = 13'd0;
      send_frame(8'h96, 0, 2, "cpb0");
      cpb = 13'd1;
      send_frame(8'h69, 0, 2, "cpb1");
      cpb = 13'd2;
      send_frame(8'hC3, 0, 2, "cpb2");
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_parity();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_frame();
      test_min_rate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
